// File: rtl/nco_pkg.sv
// Shared NCO package: default widths, sweep FSM state encoding and the
// phase-increment type used by the sweep controller and the NCO wrapper.
package nco_pkg;

    localparam int unsigned APR = 32;   // phase-increment / accumulator width
    localparam int unsigned CW  = 16;   // step and dwell counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    typedef logic [APR-1:0] phi_inc_t;

endpackage : nco_pkg

// File: rtl/nco_sweep_timer.sv
// Dwell down-counter for the sweep controller.
// Ports:
//   clk, reset   - clock, async active-high reset
//   load         - load counter with load_val (has priority over en)
//   en           - decrement when non-zero
//   load_val     - reload value
//   zero         - counter currently equals zero
module nco_sweep_timer #(
    parameter int unsigned CW = nco_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // Saturating down-counter; stops at zero until reloaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule : nco_sweep_timer

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear-chirp controller driving the NCO phase increment.
// Ports:
//   clk, reset   - clock, async active-high reset
//   clken        - clock enable shared with the NCO
//   start        - sweep request (sampled in IDLE)
//   abort        - return to IDLE, ignores clken
//   repeat_en    - restart from f_start after the last step
//   f_start      - first increment (unsigned)
//   f_step       - signed per-step delta
//   n_steps      - step additions per sweep
//   dwell        - each value held dwell+1 enabled cycles
//   phi_inc_o    - phase increment to the NCO
//   busy         - sweep running
//   step_stb     - phi_inc_o just took a new value
//   done         - single-shot sweep completed
module nco_sweep_ctrl #(
    parameter int unsigned APR = nco_pkg::APR,
    parameter int unsigned CW  = nco_pkg::CW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic           start,
    input  logic           abort,
    input  logic           repeat_en,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_step,
    input  logic [CW-1:0]  n_steps,
    input  logic [CW-1:0]  dwell,
    output logic [APR-1:0] phi_inc_o,
    output logic           busy,
    output logic           step_stb,
    output logic           done
);

    import nco_pkg::*;

    sweep_state_t   state, state_nxt;
    logic [APR-1:0] phi_nxt;
    logic [CW-1:0]  step_cnt, step_cnt_nxt;

    // Sweep configuration captured at start
    logic [APR-1:0] f_start_lat, f_start_lat_nxt;
    logic [APR-1:0] f_step_lat, f_step_lat_nxt;
    logic [CW-1:0]  n_steps_lat, n_steps_lat_nxt;
    logic [CW-1:0]  dwell_lat, dwell_lat_nxt;
    logic           repeat_lat, repeat_lat_nxt;

    logic           stb_nxt, done_nxt, busy_nxt;
    logic           tmr_load, tmr_en, tmr_zero;
    logic [CW-1:0]  tmr_load_val;

    nco_sweep_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phi_inc_o   <= '0;
            step_cnt    <= '0;
            f_start_lat <= '0;
            f_step_lat  <= '0;
            n_steps_lat <= '0;
            dwell_lat   <= '0;
            repeat_lat  <= 1'b0;
            busy        <= 1'b0;
            step_stb    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            phi_inc_o   <= phi_nxt;
            step_cnt    <= step_cnt_nxt;
            f_start_lat <= f_start_lat_nxt;
            f_step_lat  <= f_step_lat_nxt;
            n_steps_lat <= n_steps_lat_nxt;
            dwell_lat   <= dwell_lat_nxt;
            repeat_lat  <= repeat_lat_nxt;
            busy        <= busy_nxt;
            step_stb    <= stb_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state and datapath control; abort overrides everything, clken
    // gates all other progress so pulses are only raised on enabled edges.
    always_comb begin
        state_nxt       = state;
        phi_nxt         = phi_inc_o;
        step_cnt_nxt    = step_cnt;
        f_start_lat_nxt = f_start_lat;
        f_step_lat_nxt  = f_step_lat;
        n_steps_lat_nxt = n_steps_lat;
        dwell_lat_nxt   = dwell_lat;
        repeat_lat_nxt  = repeat_lat;
        stb_nxt         = 1'b0;
        done_nxt        = 1'b0;
        tmr_load        = 1'b0;
        tmr_en          = 1'b0;
        tmr_load_val    = dwell_lat;

        if (abort) begin
            state_nxt = IDLE;
        end else if (clken) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        f_start_lat_nxt = f_start;
                        f_step_lat_nxt  = f_step;
                        n_steps_lat_nxt = n_steps;
                        dwell_lat_nxt   = dwell;
                        repeat_lat_nxt  = repeat_en;
                        phi_nxt         = f_start;
                        step_cnt_nxt    = '0;
                        tmr_load        = 1'b1;
                        tmr_load_val    = dwell;
                        stb_nxt         = 1'b1;
                        state_nxt       = RUN;
                    end
                end
                RUN: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (step_cnt != n_steps_lat) begin
                        phi_nxt      = phi_inc_o + f_step_lat;
                        step_cnt_nxt = step_cnt + CW'(1);
                        tmr_load     = 1'b1;
                        stb_nxt      = 1'b1;
                    end else if (repeat_lat) begin
                        phi_nxt      = f_start_lat;
                        step_cnt_nxt = '0;
                        tmr_load     = 1'b1;
                        stb_nxt      = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt == RUN);
    end

endmodule : nco_sweep_ctrl

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed scenarios plus random
// stimulus, all compared against an arithmetic sweep model.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        start;
    logic        abort;
    logic        repeat_en;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic [31:0] phi_inc_o;
    logic        busy;
    logic        step_stb;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    nco_sweep_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .start     (start),
        .abort     (abort),
        .repeat_en (repeat_en),
        .f_start   (f_start),
        .f_step    (f_step),
        .n_steps   (n_steps),
        .dwell     (dwell),
        .phi_inc_o (phi_inc_o),
        .busy      (busy),
        .step_stb  (step_stb),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: the output is a function of the number of enabled
    // edges j since the sweep was accepted. Segment j/(dwell+1) selects
    // f_start + seg*f_step; a single-shot sweep ends at j = (n+1)(dwell+1).
    int          m_mode;      // 0 idle, 1 running, 2 done
    longint      m_j;
    logic [31:0] m_fs, m_fstep;
    longint      m_n, m_len;
    bit          m_rep;
    logic [31:0] m_phi;
    bit          m_busy, m_stb, m_done;

    task automatic model_reset();
        m_mode = 0; m_j = 0; m_phi = '0;
        m_busy = 0; m_stb = 0; m_done = 0;
    endtask

    task automatic model_edge();
        longint      seg;
        logic [63:0] v;
        if (reset) begin
            model_reset();
        end else if (abort) begin
            m_mode = 0; m_busy = 0; m_stb = 0; m_done = 0;
        end else if (!clken) begin
            m_stb = 0; m_done = 0;
        end else begin
            m_stb = 0; m_done = 0;
            case (m_mode)
                0: if (start) begin
                    m_fs = f_start; m_fstep = f_step;
                    m_n = longint'(n_steps); m_len = longint'(dwell) + 1;
                    m_rep = repeat_en;
                    m_j = 0; m_mode = 1; m_busy = 1;
                    m_phi = f_start; m_stb = 1;
                end
                1: begin
                    m_j++;
                    if (!m_rep && m_j == (m_n + 1) * m_len) begin
                        m_mode = 2; m_busy = 0; m_done = 1;
                    end else begin
                        seg = m_j / m_len;
                        if (m_rep) seg = seg % (m_n + 1);
                        v = 64'(m_fs) + 64'(seg) * 64'(m_fstep);
                        m_phi = v[31:0];
                        m_stb = (m_j % m_len) == 0;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("phi_inc_o", phi_inc_o, m_phi);
        check("busy", 32'(busy), 32'(m_busy));
        check("step_stb", 32'(step_stb), 32'(m_stb));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic cfg(input logic [31:0] fs, input logic [31:0] fst,
                       input logic [15:0] n, input logic [15:0] dw, input logic rep);
        f_start = fs; f_step = fst; n_steps = n; dwell = dw; repeat_en = rep;
    endtask

    // Run cycles until the model is idle, bounded.
    task automatic drain();
        int guard = 0;
        while (m_mode != 0 && guard < 500) begin
            cycle();
            guard++;
        end
        check("drain_timeout", 32'(m_mode), 32'd0);
    endtask

    logic [31:0] held;

    initial begin
        model_reset();
        reset = 1'b1; clken = 1'b1; start = 1'b0; abort = 1'b0;
        cfg(32'h0, 32'h0, 16'd0, 16'd0, 1'b0);
        cycle();
        check("reset_phi", phi_inc_o, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        cycle();
        reset = 1'b0;
        cycle();

        // Up sweep, 4 values x 3 cycles, done 12 edges after first change
        cfg(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd2, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        check("up_first", phi_inc_o, 32'h0100_0000);
        repeat (3) cycle();
        check("up_second", phi_inc_o, 32'h0110_0000);
        repeat (8) cycle();
        check("up_last", phi_inc_o, 32'h0130_0000);
        check("up_not_done_yet", 32'(done), 32'd0);
        cycle();
        check("up_done", 32'(done), 32'd1);
        check("up_busy_fall", 32'(busy), 32'd0);
        drain();

        // Wrap through 2^32
        cfg(32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 16'd0, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        check("wrap_value", phi_inc_o, 32'h0000_0010);
        drain();

        // Negative step
        cfg(32'h0000_0010, 32'hFFFF_FFF0, 16'd1, 16'd0, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        check("neg_value", phi_inc_o, 32'h0000_0000);
        drain();

        // Back-to-back with start held high
        cfg(32'h1234, 32'h1, 16'd0, 16'd0, 1'b0);
        start = 1'b1;
        repeat (8) cycle();
        start = 1'b0;
        drain();

        // Repeat mode, then abort
        cfg(32'h0000_1000, 32'h0000_0100, 16'd1, 16'd0, 1'b1);
        start = 1'b1; cycle(); start = 1'b0;
        repeat (9) cycle();
        check("rep_busy", 32'(busy), 32'd1);
        held = phi_inc_o;
        abort = 1'b1; cycle(); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hold", phi_inc_o, held);
        cycle();

        // start + abort together: no sweep
        held = phi_inc_o;
        cfg(32'hDEAD_0000, 32'h1, 16'd2, 16'd1, 1'b0);
        start = 1'b1; abort = 1'b1; cycle(); start = 1'b0; abort = 1'b0;
        check("collide_busy", 32'(busy), 32'd0);
        check("collide_hold", phi_inc_o, held);
        cycle();

        // clken 1010 during dwell=1 sweep
        cfg(32'h0000_0500, 32'h0000_0005, 16'd3, 16'd1, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            clken = (i % 2) == 1;
            cycle();
        end
        clken = 1'b1;
        drain();

        // Start pulsed in RUN and n_steps changed mid-sweep
        cfg(32'h0000_0A00, 32'h0000_0010, 16'd2, 16'd0, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        n_steps = 16'd7; f_start = 32'h0;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        check("nsteps_last", phi_inc_o, 32'h0000_0A20);
        cycle();
        check("nsteps_done", 32'(done), 32'd1);
        drain();

        // Async reset mid-dwell, off a clock edge
        cfg(32'h7777_0000, 32'h0000_0001, 16'd2, 16'd5, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        repeat (2) cycle();
        #3 reset = 1'b1;
        #1;
        check("areset_phi", phi_inc_o, 32'h0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_stb", 32'(step_stb), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        model_reset();
        cycle();
        #2 reset = 1'b0;
        repeat (20) cycle();

        // Random stimulus, configuration changing every cycle
        for (int i = 0; i < 3000; i++) begin
            clken     = $urandom_range(0, 3) != 0;
            start     = $urandom_range(0, 3) == 0;
            abort     = $urandom_range(0, 60) == 0;
            repeat_en = $urandom_range(0, 5) == 0;
            f_start   = $urandom;
            f_step    = $urandom;
            n_steps   = 16'($urandom_range(0, 4));
            dwell     = 16'($urandom_range(0, 3));
            cycle();
        end
        start = 1'b0; abort = 1'b1; clken = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_nco_sweep_ctrl

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep controller that drives the 32-bit phase-increment input of the NCO. It generates a stepped linear chirp: it loads a start increment, holds each increment for a programmable dwell, and adds a signed step a programmable number of times. Sweeps run once or repeat continuously. The block sits directly upstream of the NCO's `phi_inc_i` port and shares its `clk`/`clken` domain.

## Interface
- `APR`, 32: phase-increment width; must match the NCO accumulator width.
- `CW`, 16: width of the step counter and the dwell counter.
- `clk`, in, 1: system clock, the same clock as the NCO.
- `reset`, in, 1: asynchronous, active-high reset.
- `clken`, in, 1: clock enable; all state advances only when high (`abort` excepted).
- `start`, in, 1: level-sampled sweep request; honoured only in IDLE with `clken`=1.
- `abort`, in, 1: terminates the sweep; honoured regardless of `clken`.
- `repeat_en`, in, 1: 1 = restart the sweep from `f_start` after the last step; 0 = single shot.
- `f_start`, in, APR: first increment (unsigned).
- `f_step`, in, APR: per-step increment delta (two's complement).
- `n_steps`, in, CW: number of step additions per sweep (0 = hold `f_start` only).
- `dwell`, in, CW: each increment is held for `dwell`+1 enabled cycles.
- `phi_inc_o`, out, APR: connects to NCO `phi_inc_i`.
- `busy`, out, 1: high in state RUN.
- `step_stb`, out, 1: one-cycle pulse in the cycle where `phi_inc_o` takes a new value.
- `done`, out, 1: one-cycle pulse at the end of a single-shot sweep.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with `phi_inc_o`=0, `busy`=0, `step_stb`=0, `done`=0.
- IDLE → RUN on `start` & `clken` & !`abort`:
  - Latch `f_step`, `n_steps`, `dwell` and `repeat_en`.
  - Load `phi_inc_o`←`f_start`, `step_cnt`←0, `dwell_cnt`←`dwell`.
  - Pulse `step_stb`.
- RUN, each `clken` cycle:
  - If `dwell_cnt`≠0: decrement `dwell_cnt`.
  - Else if `step_cnt`≠latched `n_steps`: `phi_inc_o`←`phi_inc_o`+`f_step` (mod 2^APR, silent wrap), increment `step_cnt`, reload `dwell_cnt`, pulse `step_stb`.
  - Else if `repeat_en`: `phi_inc_o`←latched `f_start`, `step_cnt`←0, reload `dwell_cnt`, pulse `step_stb`.
  - Else → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally. `phi_inc_o` holds the last value.
- `abort` (any state, any `clken`): → IDLE next edge. `phi_inc_o` holds, `step_stb`/`done` are not asserted, `busy`=0.
- `abort` and `start` in the same cycle: `abort` wins and no sweep starts.
- `start` in RUN or DONE: ignored. Config inputs changing during RUN: ignored (latched copies are used).
- `clken`=0: all registers hold and pulse outputs are 0 in that cycle; a pulse is never stretched.
- Reset mid-sweep: immediate return to reset values with no `done` pulse.

## Timing
- All outputs are registered. `phi_inc_o` changes on the first edge after `start` is sampled.
- Each increment value is present for exactly `dwell`+1 `clken`-high cycles.
- Single-shot sweep length: (`n_steps`+1)·(`dwell`+1) enabled cycles in RUN, plus 1 cycle in DONE.
- `done` asserts on the enabled edge following the last dwell cycle. `busy` falls on the same edge.
- `step_stb` coincides with the cycle `phi_inc_o` first shows the new value.
- Back-to-back: `start` held high re-enters RUN on the cycle after DONE, i.e. IDLE is occupied for 1 cycle.

## Structure
- Shared package `nco_pkg`:
  - `APR`/`CW` defaults.
  - State enum `sweep_state_t` (IDLE, RUN, DONE).
  - The `phi_inc_t` typedef (logic [APR-1:0]), also used by the NCO wrapper.
- One sub-module, `nco_sweep_timer`: a CW-bit dwell down-counter with load/enable and a `zero` flag. The FSM, step counter and accumulator stay in the top.

## Test plan
- Up sweep: `f_start`=0x0100_0000, `f_step`=0x0010_0000, `n_steps`=3, `dwell`=2, single shot → values 0x0100_0000/0x0110_0000/0x0120_0000/0x0130_0000, each for 3 cycles; 4 `step_stb` pulses; `done` 12 cycles after the first change.
- Wrap and negative step:
  - `f_start`=0xFFFF_FFF0, `f_step`=0x20, `n_steps`=1 → second value 0x0000_0010.
  - `f_step`=0xFFFF_FFF0 (-16) from 0x10 → 0x0.
- Repeat: `repeat_en`=1, `n_steps`=1, `dwell`=0 → alternating `f_start`, `f_start`+`f_step` every cycle; `busy` stays 1 and `done` never asserts until `abort`. `abort` → `busy`=0 next cycle with `phi_inc_o` held.
- `clken` pattern 1010… during a `dwell`=1 sweep → every value held for 2 enabled (4 real) cycles; `step_stb` is 1 cycle wide.
- Collisions:
  - `start`+`abort` same cycle → stays IDLE, `phi_inc_o` unchanged.
  - `start` pulsed in RUN → ignored.
  - `n_steps` changed mid-sweep → original count honoured.
- Async `reset` asserted mid-dwell, off a clock edge → all outputs 0 immediately; no `done` pulse.
